// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state codes, bus direction constants and transfer sizing helper
package i2c_pkg;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_ACKCHK = 4'd3;
  localparam logic [3:0] S_SUBA   = 4'd4;
  localparam logic [3:0] S_WDAT   = 4'd5;
  localparam logic [3:0] S_RSTART = 4'd6;
  localparam logic [3:0] S_RADDR  = 4'd7;
  localparam logic [3:0] S_RDAT   = 4'd8;
  localparam logic [3:0] S_MACK   = 4'd9;
  localparam logic [3:0] S_STOP   = 4'd10;
  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;
  function automatic int byte_count(input int addr_bytes, input int data_bytes);
    return 1 + addr_bytes + data_bytes;
  endfunction
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: divides CLOCK into SCL quarter ticks and tracks the current quarter q0..q3
module i2c_phase_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       clr,
  output logic       q_tick,
  output logic [1:0] phase
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign q_tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      cnt   <= '0;
      phase <= '0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= '0;
    end else if (q_tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else
      cnt <= cnt + CW'(1);
endmodule

// File: rtl/i2c_xfer_engine.sv
// i2c_xfer_engine: I2C master for register writes and repeated-start reads, aborting with a stop on NACK
module i2c_xfer_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    GO,
  input  logic                    W_R,
  input  logic [6:0]              SLAVE_ADDR,
  input  logic [8*ADDR_BYTES-1:0] SUB_ADDR,
  input  logic [8*DATA_BYTES-1:0] WDATA,
  output logic [8*DATA_BYTES-1:0] RDATA,
  output logic                    BUSY,
  output logic                    END,
  output logic                    ACK,
  output logic                    I2C_SCLK,
  inout  wire                     I2C_SDAT
);
  logic [3:0] state, pst;
  logic [6:0] addr_q;
  logic rw_q;
  logic [8*ADDR_BYTES-1:0] sub_q;
  logic [8*DATA_BYTES-1:0] wd_q;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt, phase;
  logic q_tick, accept, smp, slot_end, last_ab, last_db, byte_st, sda_q, sda_in, scl_d, sda_d;
  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clr   (accept),
    .q_tick(q_tick),
    .phase (phase)
  );
  assign BUSY     = state != S_IDLE;
  assign END      = !BUSY;
  assign accept   = GO && !BUSY;
  assign smp      = q_tick && phase == 2'd2;
  assign slot_end = q_tick && phase == 2'd3;
  assign last_ab  = byte_cnt == 2'(ADDR_BYTES - 1);
  assign last_db  = byte_cnt == 2'(DATA_BYTES - 1);
  assign byte_st  = state inside {S_ADDR, S_SUBA, S_WDAT, S_RADDR};
  assign I2C_SDAT = sda_q ? 1'bz : 1'b0;
  assign sda_in   = I2C_SDAT;
  assign scl_d    = (state == S_IDLE || state == S_START) ? 1'b1 : phase[1];
  assign sda_d    = (state == S_START || state == S_RSTART) ? phase != 2'd3 :
                    state == S_STOP ? phase == 2'd3 :
                    byte_st ? sh[7] :
                    state == S_MACK ? last_db : 1'b1;
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state    <= S_IDLE;
      pst      <= S_IDLE;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      sub_q    <= '0;
      wd_q     <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ACK      <= 1'b0;
      RDATA    <= '0;
      I2C_SCLK <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      I2C_SCLK <= scl_d;
      sda_q    <= sda_d;
      if (accept) begin
        state  <= S_START;
        addr_q <= SLAVE_ADDR;
        rw_q   <= W_R;
        sub_q  <= SUB_ADDR;
        wd_q   <= WDATA;
        ACK    <= 1'b0;
      end else begin
        if (smp && state == S_ACKCHK && sda_in) ACK <= 1'b1;
        if (smp && state == S_RDAT) RDATA <= {RDATA[8*DATA_BYTES-2:0], sda_in};
        if (slot_end)
          case (state)
            S_START: begin
              state   <= S_ADDR;
              sh      <= {addr_q, I2C_WR};
              bit_cnt <= 3'd7;
            end
            S_ADDR, S_SUBA, S_WDAT, S_RADDR, S_RDAT:
              if (bit_cnt == 3'd0) begin
                state <= state == S_RDAT ? S_MACK : S_ACKCHK;
                pst   <= state;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                sh      <= {sh[6:0], 1'b0};
              end
            S_ACKCHK: begin
              bit_cnt <= 3'd7;
              if (ACK) state <= S_STOP;
              else if (pst == S_ADDR || (pst == S_SUBA && !last_ab)) begin
                state    <= S_SUBA;
                byte_cnt <= pst == S_ADDR ? 2'd0 : byte_cnt + 2'd1;
                sh       <= sub_q[8*ADDR_BYTES-1 -: 8];
                sub_q    <= sub_q << 8;
              end else if ((pst == S_SUBA && !rw_q) || (pst == S_WDAT && !last_db)) begin
                state    <= S_WDAT;
                byte_cnt <= pst == S_SUBA ? 2'd0 : byte_cnt + 2'd1;
                sh       <= wd_q[8*DATA_BYTES-1 -: 8];
                wd_q     <= wd_q << 8;
              end else if (pst == S_SUBA) state <= S_RSTART;
              else if (pst == S_WDAT) state <= S_STOP;
              else begin
                state    <= S_RDAT;
                byte_cnt <= 2'd0;
              end
            end
            S_RSTART: begin
              state   <= S_RADDR;
              sh      <= {addr_q, I2C_RD};
              bit_cnt <= 3'd7;
            end
            S_MACK:
              if (last_db) state <= S_STOP;
              else begin
                state    <= S_RDAT;
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= 3'd7;
              end
            S_STOP: state <= S_IDLE;
            default: ;
          endcase
      end
    end
endmodule
